// File: rtl/imem_loader.sv
// imem_loader: boot-time loader for the instruction memory write port.
// Accepts a length-prefixed byte stream (first byte = word count N), packs
// each group of four bytes little-endian into a 32-bit word and writes it to
// sequential imem addresses. cpu_hold stays high until the image is complete.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. When defined, a trailing
// checksum byte (XOR of every byte, including N) is checked before DONE.
module imem_loader #(
   parameter int ADDR_W    = 5,
   parameter int MAX_WORDS = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [ADDR_W-1:0] imem_address,
   output logic [31:0]       imem_data_in,
   output logic              imem_rw,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_LEN, S_BYTES, S_WRITE, S_DONE, S_ERROR, S_CSUM
   } state_t;
   // After the last word (or N=0) the checksum byte is still outstanding
   localparam state_t S_AFTER_LAST = S_CSUM;
`else
   typedef enum logic [2:0] {
      S_LEN, S_BYTES, S_WRITE, S_DONE, S_ERROR
   } state_t;
   localparam state_t S_AFTER_LAST = S_DONE;
`endif

   // Word count limit in the width of the length byte
   localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

   state_t state_reg, state_next;

   logic [7:0]        n_reg;          // latched word count N
   logic [7:0]        word_idx_reg;   // index of the word being assembled
   logic [1:0]        byte_idx_reg;   // byte position inside the word
   logic [23:0]       asm_word;       // lower three bytes of the word in flight

   logic              rx_ready_reg,     rx_ready_next;
   logic [ADDR_W-1:0] imem_address_reg, imem_address_next;
   logic [31:0]       imem_data_in_reg, imem_data_in_next;
   logic              imem_rw_reg,      imem_rw_next;
   logic              cpu_hold_reg,     cpu_hold_next;
   logic              load_done_reg,    load_done_next;
   logic              load_error_reg,   load_error_next;

   logic              xfer;
   logic              rearm;

   assign xfer  = rx_valid && rx_ready_reg;
   assign rearm = start && ((state_reg == S_DONE) || (state_reg == S_ERROR));

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] csum_reg;

   // Running XOR of every accepted byte, starting with the N byte
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         csum_reg <= 8'd0;
      end else if (state_reg == S_LEN && xfer) begin
         csum_reg <= rx_data;
      end else if (state_reg == S_BYTES && xfer) begin
         csum_reg <= csum_reg ^ rx_data;
      end else if (rearm) begin
         csum_reg <= 8'd0;
      end
   end
`endif

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= S_LEN;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state decode
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_LEN: begin
            if (xfer) begin
               if (rx_data == 8'd0) begin
                  state_next = S_AFTER_LAST;
               end else if (rx_data > MAX_N) begin
                  state_next = S_ERROR;
               end else begin
                  state_next = S_BYTES;
               end
            end
         end
         S_BYTES: begin
            if (xfer && byte_idx_reg == 2'd3) begin
               state_next = S_WRITE;
            end
         end
         S_WRITE: begin
            if (word_idx_reg + 8'd1 == n_reg) begin
               state_next = S_AFTER_LAST;
            end else begin
               state_next = S_BYTES;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (xfer) begin
               state_next = (rx_data == csum_reg) ? S_DONE : S_ERROR;
            end
         end
`endif
         S_DONE, S_ERROR: begin
            if (start) begin
               state_next = S_LEN;
            end
         end
         default: state_next = S_LEN;
      endcase
   end

   // Output decode from the upcoming state, so every output is a register
   always_comb begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      rx_ready_next = (state_next == S_LEN) || (state_next == S_BYTES) ||
                      (state_next == S_CSUM);
`else
      rx_ready_next = (state_next == S_LEN) || (state_next == S_BYTES);
`endif
      imem_rw_next      = (state_next != S_WRITE);
      imem_address_next = imem_address_reg;
      imem_data_in_next = imem_data_in_reg;
      if (state_next == S_WRITE) begin
         // The fourth byte is still on rx_data; it becomes the top byte
         imem_address_next = word_idx_reg[ADDR_W-1:0];
         imem_data_in_next = {rx_data, asm_word};
      end
      cpu_hold_next   = (state_next != S_DONE);
      load_done_next  = (state_next == S_DONE) && (state_reg != S_DONE);
      load_error_next = (state_next == S_ERROR);
   end

   // Output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_ready_reg     <= 1'b1;
         imem_address_reg <= '0;
         imem_data_in_reg <= 32'd0;
         imem_rw_reg      <= 1'b1;
         cpu_hold_reg     <= 1'b1;
         load_done_reg    <= 1'b0;
         load_error_reg   <= 1'b0;
      end else begin
         rx_ready_reg     <= rx_ready_next;
         imem_address_reg <= imem_address_next;
         imem_data_in_reg <= imem_data_in_next;
         imem_rw_reg      <= imem_rw_next;
         cpu_hold_reg     <= cpu_hold_next;
         load_done_reg    <= load_done_next;
         load_error_reg   <= load_error_next;
      end
   end

   // Word count, word index and byte index bookkeeping
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         n_reg        <= 8'd0;
         word_idx_reg <= 8'd0;
         byte_idx_reg <= 2'd0;
      end else if (state_reg == S_LEN && xfer) begin
         n_reg        <= rx_data;
         word_idx_reg <= 8'd0;
         byte_idx_reg <= 2'd0;
      end else if (state_reg == S_BYTES && xfer) begin
         byte_idx_reg <= byte_idx_reg + 2'd1;
      end else if (state_reg == S_WRITE) begin
         word_idx_reg <= word_idx_reg + 8'd1;
      end else if (rearm) begin
         n_reg        <= 8'd0;
         word_idx_reg <= 8'd0;
         byte_idx_reg <= 2'd0;
      end
   end

   // One capture register per low byte lane; the top byte goes straight
   // from rx_data into the write word
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_lane
         logic [7:0] lane_reg;

         // Capture this lane when its byte index is accepted
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               lane_reg <= 8'd0;
            end else if (state_reg == S_BYTES && xfer && byte_idx_reg == 2'(gi)) begin
               lane_reg <= rx_data;
            end
         end

         assign asm_word[8*gi +: 8] = lane_reg;
      end
   endgenerate

   assign rx_ready     = rx_ready_reg;
   assign imem_address = imem_address_reg;
   assign imem_data_in = imem_data_in_reg;
   assign imem_rw      = imem_rw_reg;
   assign cpu_hold     = cpu_hold_reg;
   assign load_done    = load_done_reg;
   assign load_error   = load_error_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table of images plus hand-written sequences,
// with a write scoreboard fed when words are driven.
module tb_imem_loader;
   localparam int ADDR_W    = 5;
   localparam int MAX_WORDS = 32;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [ADDR_W-1:0] imem_address;
   logic [31:0]       imem_data_in;
   logic              imem_rw;
   logic              cpu_hold;
   logic              load_done;
   logic              load_error;

   always #5 clk = ~clk;

   imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .imem_address (imem_address),
      .imem_data_in (imem_data_in),
      .imem_rw      (imem_rw),
      .cpu_hold     (cpu_hold),
      .load_done    (load_done),
      .load_error   (load_error)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [7:0] n;
      int         words;
      logic       exp_done;
      logic       exp_err;
   } vec_t;

   wr_t        exp_q[$];
   wr_t        mon_e;
   vec_t       vecs[7];
   int         n_checks    = 0;
   int         n_pass      = 0;
   int         done_pulses = 0;
   int         write_count = 0;
   logic [7:0] csum_acc    = 8'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
   endtask

   // Monitor: counts done pulses and scores every write strobe
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (load_done === 1'b1) done_pulses++;
         if (imem_rw === 1'b0) begin
            write_count++;
            $display("write addr=%0d data=0x%08h", imem_address, imem_data_in);
            check("rx_ready_in_write", 32'(rx_ready), 32'd0);
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_write: addr=%0d data=0x%08h, required no write",
                        imem_address, imem_data_in);
            end else begin
               mon_e = exp_q.pop_front();
               check("write_addr", 32'(imem_address), mon_e.addr);
               check("write_data", imem_data_in, mon_e.data);
            end
         end
      end
   end

   // Drive one byte; returns 1 time unit after the accepting edge
   task automatic send_byte(input logic [7:0] b);
      int cnt = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (rx_ready !== 1'b1 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 100) begin
         n_checks++;
         $display("FAIL rx_ready_timeout: byte 0x%02h rx_ready=%b, required 1", b, rx_ready);
         rx_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         rx_valid = 1'b0;
         csum_acc = csum_acc ^ b;
         $display("byte 0x%02h accepted", b);
      end
   endtask

   task automatic send_b(input logic [7:0] b);
      send_byte(b);
      @(negedge clk);
   endtask

   task automatic send_n(input logic [7:0] n);
      csum_acc = 8'd0;
      send_b(n);
   endtask

   task automatic send_word(input logic [31:0] w, input int addr, input bit gap);
      wr_t e;
      e.addr = 32'(addr);
      e.data = w;
      exp_q.push_back(e);
      for (int k = 0; k < 4; k++) begin
         send_b(w[8*k +: 8]);
         if (gap) @(negedge clk);
      end
   endtask

   task automatic send_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_b(csum_acc);
`endif
   endtask

   task automatic finish_image(input logic exp_done, input logic exp_err,
                               input int done0, input int wr0, input int exp_writes);
      int cnt = 0;
      while (cpu_hold !== 1'b0 && load_error !== 1'b1 && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      repeat (3) @(negedge clk);
      check("end_timeout", 32'(cnt < 200), 32'd1);
      check("cpu_hold_end", 32'(cpu_hold), 32'(!exp_done));
      check("load_error_end", 32'(load_error), 32'(exp_err));
      check("rx_ready_end", 32'(rx_ready), 32'd0);
      check("load_done_pulses", 32'(done_pulses - done0), 32'(exp_done));
      check("write_count", 32'(write_count - wr0), 32'(exp_writes));
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic rearm();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("rearm_load_error", 32'(load_error), 32'd0);
      check("rearm_cpu_hold", 32'(cpu_hold), 32'd1);
      check("rearm_rx_ready", 32'(rx_ready), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int done0;
      int wr0;

      vecs[0] = '{8'd2,   2,  1'b1, 1'b0};
      vecs[1] = '{8'd3,   3,  1'b1, 1'b0};
      vecs[2] = '{8'd0,   0,  1'b1, 1'b0};
      vecs[3] = '{8'd33,  0,  1'b0, 1'b1};
      vecs[4] = '{8'd32,  32, 1'b1, 1'b0};
      vecs[5] = '{8'd255, 0,  1'b0, 1'b1};
      vecs[6] = '{8'd1,   1,  1'b1, 1'b0};

      reset_n  = 1'b0;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'd0;
      repeat (3) @(negedge clk);
      check("reset_rx_ready", 32'(rx_ready), 32'd1);
      check("reset_imem_rw", 32'(imem_rw), 32'd1);
      check("reset_cpu_hold", 32'(cpu_hold), 32'd1);
      check("reset_load_done", 32'(load_done), 32'd0);
      check("reset_load_error", 32'(load_error), 32'd0);
      check("reset_address", 32'(imem_address), 32'd0);
      check("reset_data", imem_data_in, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Single word 0xDEADBEEF with a direct look at the write strobe cycle
      done0 = done_pulses;
      wr0   = write_count;
      send_n(8'h01);
      exp_q.push_back('{32'd0, 32'hDEADBEEF});
      send_b(8'hEF);
      send_b(8'hBE);
      send_b(8'hAD);
      send_byte(8'hDE);
      check("strobe_rw", 32'(imem_rw), 32'd0);
      check("strobe_addr", 32'(imem_address), 32'd0);
      check("strobe_data", imem_data_in, 32'hDEADBEEF);
      check("strobe_rx_ready", 32'(rx_ready), 32'd0);
      @(negedge clk);
      send_csum();
      finish_image(1'b1, 1'b0, done0, wr0, 1);
      rearm();

      // Two words with rx_valid toggled every other cycle
      done0 = done_pulses;
      wr0   = write_count;
      send_n(8'h02);
      @(negedge clk);
      send_word(32'h04030201, 0, 1'b1);
      send_word(32'h08070605, 1, 1'b1);
      send_csum();
      finish_image(1'b1, 1'b0, done0, wr0, 2);
      rearm();

      // Table of images
      for (int i = 0; i < 7; i++) begin
         done0 = done_pulses;
         wr0   = write_count;
         send_n(vecs[i].n);
         for (int w = 0; w < vecs[i].words; w++) send_word($urandom, w, 1'b0);
         if (!vecs[i].exp_err) send_csum();
         if (vecs[i].exp_err) begin
            // Bytes offered while in ERROR must not be taken
            rx_valid = 1'b1;
            rx_data  = 8'h55;
            repeat (3) @(negedge clk);
            check("error_rx_ready", 32'(rx_ready), 32'd0);
            rx_valid = 1'b0;
         end
         finish_image(vecs[i].exp_done, vecs[i].exp_err, done0, wr0, vecs[i].words);
         rearm();
      end

      // Reset during the write cycle of word 1
      send_n(8'h02);
      send_word(32'hA5A5A5A5, 0, 1'b0);
      send_b(8'h11);
      send_b(8'h22);
      send_b(8'h33);
      send_byte(8'h44);
      check("pre_reset_rw", 32'(imem_rw), 32'd0);
      reset_n = 1'b0;
      #1;
      check("async_reset_rw", 32'(imem_rw), 32'd1);
      check("async_reset_cpu_hold", 32'(cpu_hold), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_reset_rx_ready", 32'(rx_ready), 32'd1);
      done0 = done_pulses;
      wr0   = write_count;
      send_n(8'h01);
      send_word(32'hCAFEF00D, 0, 1'b0);
      send_csum();
      finish_image(1'b1, 1'b0, done0, wr0, 1);
      rearm();

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Correct checksum
      done0 = done_pulses;
      wr0   = write_count;
      send_n(8'h01);
      send_word(32'h44332211, 0, 1'b0);
      send_b(8'h45);
      finish_image(1'b1, 1'b0, done0, wr0, 1);
      rearm();

      // Wrong checksum
      done0 = done_pulses;
      wr0   = write_count;
      send_n(8'h01);
      send_word(32'h44332211, 0, 1'b0);
      send_b(8'h00);
      finish_image(1'b0, 1'b1, done0, wr0, 1);
      rearm();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
